// File: rtl/calc_rpn_seq_pkg.sv
// Shared definitions for the RPN calculator: character codes, fault codes,
// FSM states and stack operation encodings.
package calc_rpn_seq_pkg;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_SUB = 8'h2D;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_EQ  = 8'h3D;

  typedef enum logic [2:0] {
    FLT_NONE    = 3'd0,
    FLT_ILLEGAL = 3'd1,
    FLT_UNDER   = 3'd2,
    FLT_OVER    = 3'd3,
    FLT_NOEQ    = 3'd4,
    FLT_DEPTH   = 3'd5
  } fault_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STK_NONE      = 2'd0,
    STK_PUSH      = 2'd1,
    STK_POP1_PUSH = 2'd2,
    STK_POP2_PUSH = 2'd3
  } stk_op_e;

  function automatic logic is_digit(input logic [7:0] ch);
    return (ch >= CH_0) && (ch <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] ch);
    return (ch == CH_ADD) || (ch == CH_SUB) || (ch == CH_MUL);
  endfunction

endpackage

// File: rtl/calc_rpn_seq_if.sv
// Host/ROM side bus of the RPN calculator; master = host + ROM, slave = calculator.
interface calc_rpn_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              St;
  logic [7:0]        Instr;
  logic [ADDR_W-1:0] Instr_Addr;
  logic              Busy;
  logic              Finish;
  logic [DATA_W-1:0] Result;
  logic              Fault;
  logic [2:0]        Fault_Code;

  modport master (
    output St, Instr,
    input  Instr_Addr, Busy, Finish, Result, Fault, Fault_Code
  );

  modport slave (
    input  St, Instr,
    output Instr_Addr, Busy, Finish, Result, Fault, Fault_Code
  );
endinterface

// File: rtl/calc_rpn_seq_stack.sv
// Register-array operand LIFO with single-cycle push / pop1+push / pop2+push.
module calc_rpn_seq_stack
  import calc_rpn_seq_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  stk_op_e                            op,
  input  logic signed [DATA_W-1:0]           wdata,
  output logic signed [DATA_W-1:0]           top,
  output logic signed [DATA_W-1:0]           next,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic signed [DATA_W-1:0] mem_q [2**PTR_W];
  logic [CNT_W-1:0]         depth_q;
  logic [PTR_W-1:0]         push_idx, top_idx, next_idx;

  assign push_idx = PTR_W'(depth_q);
  assign top_idx  = PTR_W'(depth_q - CNT_W'(1));
  assign next_idx = PTR_W'(depth_q - CNT_W'(2));

  assign top   = mem_q[top_idx];
  assign next  = mem_q[next_idx];
  assign depth = depth_q;
  assign full  = (depth_q == CNT_W'(STACK_DEPTH));
  assign empty = (depth_q == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      depth_q <= '0;
    end else begin
      case (op)
        STK_PUSH:      depth_q <= depth_q + CNT_W'(1);
        STK_POP2_PUSH: depth_q <= depth_q - CNT_W'(1);
        default:       ;
      endcase
    end
  end

  // Entries are only ever read below the pointer, so the array needs no reset.
  always_ff @(posedge clk) begin
    case (op)
      STK_PUSH:      mem_q[push_idx] <= wdata;
      STK_POP1_PUSH: mem_q[top_idx]  <= wdata;
      STK_POP2_PUSH: mem_q[next_idx] <= wdata;
      default:       ;
    endcase
  end

endmodule

// File: rtl/calc_rpn_seq.sv
// Streaming RPN calculator: fetches one ASCII character per clock from a
// synchronous ROM, tokenises it and evaluates it on the operand stack.
module calc_rpn_seq
  import calc_rpn_seq_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 8,
  parameter int MAX_LEN     = 64
) (
  input  logic           Sysclk,
  input  logic           Rst,
  calc_rpn_seq_if.slave  bus
);
  localparam int              CNT_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_LEN - 1);

  state_e                   state_q, state_n;
  logic [ADDR_W-1:0]        addr_q, cnt_q;
  logic [DATA_W-1:0]        acc_q, acc_n;
  logic                     pend_q, pend_n;
  logic [DATA_W-1:0]        result_q, result_n;
  fault_e                   code_q, code_n;

  stk_op_e                  stk_op;
  logic                     stk_clr;
  logic signed [DATA_W-1:0] stk_wdata, stk_top, stk_next;
  logic [CNT_W-1:0]         stk_depth;
  logic                     stk_full, stk_empty;
  logic [CNT_W:0]           avail;

  function automatic logic signed [DATA_W-1:0] alu_wrap(
    input logic [7:0]               opc,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    case (opc)
      CH_ADD:  return a + b;
      CH_SUB:  return a - b;
      default: return a * b;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] acc_shift(
    input logic [DATA_W-1:0] acc,
    input logic [7:0]        ch
  );
    logic [7:0] d;
    d = ch - CH_0;
    return acc * DATA_W'(10) + DATA_W'(d);
  endfunction

  calc_rpn_seq_stack #(
    .DATA_W      (DATA_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (Sysclk),
    .rst   (Rst),
    .clr   (stk_clr),
    .op    (stk_op),
    .wdata (stk_wdata),
    .top   (stk_top),
    .next  (stk_next),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // A pending (unpushed) number counts as an operand for the operators.
  assign avail = {1'b0, stk_depth} + {{CNT_W{1'b0}}, pend_q};

  always_comb begin
    state_n   = state_q;
    stk_op    = STK_NONE;
    stk_clr   = 1'b0;
    stk_wdata = acc_q;
    acc_n     = acc_q;
    pend_n    = pend_q;
    result_n  = result_q;
    code_n    = code_q;
    case (state_q)
      S_IDLE: begin
        if (bus.St) begin
          state_n  = S_PRIME;
          stk_clr  = 1'b1;
          acc_n    = '0;
          pend_n   = 1'b0;
          result_n = '0;
          code_n   = FLT_NONE;
        end
      end
      S_PRIME: state_n = S_RUN;
      S_RUN: begin
        if (is_digit(bus.Instr)) begin
          acc_n  = acc_shift(acc_q, bus.Instr);
          pend_n = 1'b1;
        end else if (bus.Instr == CH_SP) begin
          if (pend_q) begin
            if (stk_full) code_n = FLT_OVER;
            else          stk_op = STK_PUSH;
          end
          acc_n  = '0;
          pend_n = 1'b0;
        end else if (is_op(bus.Instr)) begin
          if (avail < (CNT_W+1)'(2)) begin
            code_n = FLT_UNDER;
          end else if (pend_q) begin
            stk_op    = STK_POP1_PUSH;
            stk_wdata = alu_wrap(bus.Instr, stk_top, acc_q);
          end else begin
            stk_op    = STK_POP2_PUSH;
            stk_wdata = alu_wrap(bus.Instr, stk_next, stk_top);
          end
          acc_n  = '0;
          pend_n = 1'b0;
        end else if (bus.Instr == CH_EQ) begin
          state_n = S_DONE;
          if (pend_q) begin
            if (stk_full)        code_n   = FLT_OVER;
            else if (!stk_empty) code_n   = FLT_DEPTH;
            else                 result_n = acc_q;
          end else if (stk_depth != CNT_W'(1)) begin
            code_n = FLT_DEPTH;
          end else begin
            result_n = stk_top;
          end
        end else begin
          code_n = FLT_ILLEGAL;
        end

        if (code_n != FLT_NONE) begin
          state_n  = S_DONE;
          stk_op   = STK_NONE;
          result_n = '0;
        end else if (state_n == S_RUN && cnt_q == LAST_IDX) begin
          state_n  = S_DONE;
          stk_op   = STK_NONE;
          code_n   = FLT_NOEQ;
          result_n = '0;
        end
      end
      S_DONE: state_n = S_IDLE;
    endcase
  end

  // State, fetch counters, accumulator and held outputs
  always_ff @(posedge Sysclk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
      result_q <= '0;
      code_q   <= FLT_NONE;
    end else begin
      state_q  <= state_n;
      acc_q    <= acc_n;
      pend_q   <= pend_n;
      result_q <= result_n;
      code_q   <= code_n;
      if (state_q == S_IDLE && bus.St) begin
        addr_q <= '0;
        cnt_q  <= '0;
      end else if (state_q == S_PRIME) begin
        addr_q <= ADDR_W'(1);
      end else if (state_q == S_RUN && state_n == S_RUN) begin
        cnt_q <= cnt_q + ADDR_W'(1);
        // The last character lives at MAX_LEN-1; never fetch past it.
        if (addr_q != LAST_IDX) addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign bus.Instr_Addr = addr_q;
  assign bus.Busy       = (state_q == S_PRIME) || (state_q == S_RUN);
  assign bus.Finish     = (state_q == S_DONE);
  assign bus.Result     = result_q;
  assign bus.Fault      = (code_q != FLT_NONE);
  assign bus.Fault_Code = code_q;

endmodule

// File: tb/tb_calc_rpn_seq.sv
// Self-checking bench for calc_rpn_seq: directed vector table, hand-written
// corner sequences and random expressions against a queue-based reference model.
module tb_calc_rpn_seq;
  localparam int MAXL  = 64;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rom [MAXL];
  int total = 0;
  int bad   = 0;
  int maxaddr;

  calc_rpn_seq_if #(.DATA_W(16), .ADDR_W(6)) bus ();

  calc_rpn_seq #(
    .DATA_W(16), .ADDR_W(6), .STACK_DEPTH(DEPTH), .MAX_LEN(MAXL)
  ) dut (
    .Sysclk (clk),
    .Rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle read latency
  always @(posedge clk) bus.Instr <= rom[bus.Instr_Addr];

  typedef struct {
    string       expr;
    logic [15:0] res;
    logic [2:0]  code;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference evaluation straight from the expression rules.
  function automatic void ref_eval(input string s, output logic [15:0] res,
                                   output logic [2:0] code, output int n);
    logic [15:0] stk[$];
    logic [15:0] acc, a, b;
    logic [7:0]  c;
    bit          pend;
    acc = '0; pend = 0; res = '0; code = 3'd0; n = 0;
    for (int k = 0; k < MAXL; k++) begin
      c = (k < s.len()) ? s[k] : 8'h00;
      n = k + 1;
      if (c >= 8'h30 && c <= 8'h39) begin
        acc = acc * 16'd10 + 16'(c - 8'h30);
        pend = 1;
      end else if (c == 8'h20) begin
        if (pend) begin
          if (stk.size() == DEPTH) code = 3'd3;
          else stk.push_back(acc);
        end
        acc = '0; pend = 0;
      end else if (c == 8'h2B || c == 8'h2D || c == 8'h2A) begin
        if (stk.size() + int'(pend) < 2) code = 3'd2;
        else begin
          if (pend) b = acc; else b = stk.pop_back();
          a = stk.pop_back();
          stk.push_back((c == 8'h2B) ? a + b : (c == 8'h2D) ? a - b : a * b);
        end
        acc = '0; pend = 0;
      end else if (c == 8'h3D) begin
        if (pend) begin
          if (stk.size() == DEPTH) code = 3'd3;
          else stk.push_back(acc);
        end
        if (code == 3'd0) begin
          if (stk.size() != 1) code = 3'd5;
          else res = stk[0];
        end
        return;
      end else begin
        code = 3'd1;
      end
      if (code != 3'd0) return;
      if (k == MAXL - 1) begin
        code = 3'd4;
        return;
      end
    end
  endfunction

  task automatic load_rom(input string s);
    for (int k = 0; k < MAXL; k++) rom[k] = (k < s.len()) ? s[k] : 8'h00;
  endtask

  task automatic run_check(input string nm, input string s, input logic [15:0] eres,
                           input logic [2:0] ecode, input int elat);
    int   lat;
    logic busy0;
    load_rom(s);
    maxaddr = 0;
    @(negedge clk); bus.St = 1'b1;
    @(posedge clk); #1; bus.St = 1'b0;
    busy0 = bus.Busy;
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk); #1;
      if (int'(bus.Instr_Addr) > maxaddr) maxaddr = int'(bus.Instr_Addr);
      if (bus.Finish) begin
        lat = e;
        break;
      end
    end
    chk({nm, " busy_start"}, 32'(busy0), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " result"}, 32'(bus.Result), 32'(eres));
    chk({nm, " fault"}, 32'(bus.Fault), 32'(ecode != 3'd0));
    chk({nm, " code"}, 32'(bus.Fault_Code), 32'(ecode));
    chk({nm, " busy_at_finish"}, 32'(bus.Busy), 32'd0);
    @(posedge clk); #1;
    chk({nm, " finish_pulse"}, 32'(bus.Finish), 32'd0);
  endtask

  initial begin
    vec_t        vecs[$];
    string       s;
    logic [15:0] mres;
    logic [2:0]  mcode;
    int          mn, extra, lat;

    bus.St = 1'b0;
    for (int k = 0; k < MAXL; k++) rom[k] = 8'h00;

    // Reset state, with St asserted to show Rst wins
    @(negedge clk); rst = 1'b1; bus.St = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(bus.Busy), 32'd0);
    chk("rst finish", 32'(bus.Finish), 32'd0);
    chk("rst addr", 32'(bus.Instr_Addr), 32'd0);
    chk("rst result", 32'(bus.Result), 32'd0);
    chk("rst fault", 32'(bus.Fault), 32'd0);
    chk("rst code", 32'(bus.Fault_Code), 32'd0);
    @(negedge clk); rst = 1'b0; bus.St = 1'b0;
    repeat (2) @(posedge clk);

    // Address sequence and latency for "12 3-="
    load_rom("12 3-=");
    @(negedge clk); bus.St = 1'b1;
    @(posedge clk); #1; bus.St = 1'b0;
    chk("seq addr e0", 32'(bus.Instr_Addr), 32'd0);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      chk($sformatf("seq addr e%0d", e), 32'(bus.Instr_Addr), 32'((e < 6) ? e : 6));
      chk($sformatf("seq finish e%0d", e), 32'(bus.Finish), 32'(e == 7));
    end
    chk("seq result", 32'(bus.Result), 32'd9);
    @(posedge clk);

    vecs.push_back('{"12 3-=",                      16'd9,     3'd0, 7});
    vecs.push_back('{"3 4+2*=",                     16'd14,    3'd0, 8});
    vecs.push_back('{"65535 1+=",                   16'd0,     3'd0, 10});
    vecs.push_back('{"7+=",                         16'd0,     3'd2, 3});
    vecs.push_back('{"1 2=",                        16'd0,     3'd5, 5});
    vecs.push_back('{"1 1 1 1 1 1 1 1 1 ",          16'd0,     3'd3, 19});
    vecs.push_back('{"1 a=",                        16'd0,     3'd1, 4});
    vecs.push_back('{"2 5-=",                       16'd65533, 3'd0, 6});
    vecs.push_back('{"8 8*8*=",                     16'd512,   3'd0, 8});
    vecs.push_back('{"  4   =",                     16'd4,     3'd0, 8});
    vecs.push_back('{"=",                           16'd0,     3'd5, 2});
    vecs.push_back('{"300 300*=",                   16'd24464, 3'd0, 10});
    vecs.push_back('{"1 1 1 1 1 1 1 1 2*+++++++=",  16'd9,     3'd0, 27});
    vecs.push_back('{"99999=",                      16'd34463, 3'd0, 7});
    vecs.push_back('{"1 2 3",                       16'd0,     3'd1, 7});
    vecs.push_back('{"1 2 3 4 5 6 7 8 9+=",         16'd0,     3'd5, 20});
    vecs.push_back('{"10 3 -=",                     16'd7,     3'd0, 8});
    for (int i = 0; i < vecs.size(); i++)
      run_check($sformatf("vec%0d", i), vecs[i].expr, vecs[i].res, vecs[i].code, vecs[i].lat);

    // No '=' within MAX_LEN characters
    s = "";
    for (int k = 0; k < MAXL; k++) s = {s, " "};
    run_check("noeq", s, 16'd0, 3'd4, MAXL + 1);
    chk("noeq max addr", 32'(maxaddr), 32'(MAXL - 1));

    // Rst in the middle of RUN
    load_rom("1 2 3 4 5++++=");
    @(negedge clk); bus.St = 1'b1;
    @(posedge clk); #1; bus.St = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst busy", 32'(bus.Busy), 32'd0);
    chk("midrst finish", 32'(bus.Finish), 32'd0);
    chk("midrst addr", 32'(bus.Instr_Addr), 32'd0);
    chk("midrst fault", 32'(bus.Fault), 32'd0);
    chk("midrst code", 32'(bus.Fault_Code), 32'd0);
    @(negedge clk); rst = 1'b0;
    extra = 0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk); #1;
      if (bus.Finish || bus.Busy) extra++;
    end
    chk("midrst no finish", 32'(extra), 32'd0);
    run_check("after_rst", "5=", 16'd5, 3'd0, 3);

    // St held high through the run and the DONE cycle
    load_rom("4 4*=");
    @(negedge clk); bus.St = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (bus.Finish) begin
        lat = e;
        break;
      end
    end
    chk("sthold latency", 32'(lat), 32'd6);
    chk("sthold result", 32'(bus.Result), 32'd16);
    @(posedge clk); #1; bus.St = 1'b0;
    extra = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (bus.Finish || bus.Busy) extra++;
    end
    chk("sthold single run", 32'(extra), 32'd0);

    // Random expressions against the reference model
    for (int t = 0; t < 40; t++) begin
      int ntok;
      s = "";
      ntok = int'($urandom_range(1, 10));
      for (int j = 0; j < ntok; j++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 5) begin
          s = {s, $sformatf("%0d", $urandom_range(0, 99999))};
          if ($urandom_range(0, 2) != 0) s = {s, " "};
        end else if (r < 9) begin
          case ($urandom_range(0, 2))
            0:       s = {s, "+"};
            1:       s = {s, "-"};
            default: s = {s, "*"};
          endcase
        end else begin
          case ($urandom_range(0, 2))
            0:       s = {s, " "};
            1:       s = {s, "a"};
            default: s = {s, "/"};
          endcase
        end
      end
      if ($urandom_range(0, 7) != 0) s = {s, "="};
      ref_eval(s, mres, mcode, mn);
      run_check($sformatf("rnd%0d", t), s, mres, mcode, mn + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
